// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the arbiter slice and the schedulers built on it.
//   htrans_t / hsize_t : AHB transfer-type and transfer-size encodings
//   MAX_NM             : largest master count the round-robin helper handles
//   rr_next()          : next requester after 'cur' in round-robin order
package ahb_pkg;

  localparam int MAX_NM = 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4W    = 3'b100,
    HSIZE_8W    = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_t;

  // Searches cur+1 .. cur+nm-1 (mod nm) and returns the first requester.
  // Returns cur when nobody else requests; the caller decides what that means.
  // The loop runs from the far end inward so the nearest requester wins last.
  function automatic logic [2:0] rr_next(input logic [MAX_NM-1:0] req,
                                         input logic [2:0] cur,
                                         input int nm);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = cur;
    for (int k = MAX_NM - 1; k >= 1; k--) begin
      idx = 3'((int'(cur) + k) % nm);
      if (k < nm && req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Bus bundle between NM AHB masters, the arbiter/mux and one shared slave.
//   slave  modport : arbiter side (takes requests and master fields, drives
//                    grant/owner indices and the muxed slave-side signals)
//   master modport : environment side (masters and slave hready)
interface ahb_arbiter_if #(
  parameter int NM = 4,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0]    hbusreq;
  logic [NM-1:0]    hlock;
  logic [NM-1:0]    hgrant;
  logic [MW-1:0]    hmaster;
  logic [MW-1:0]    hmaster_d;
  logic [NM*AW-1:0] haddr_m;
  logic [NM*2-1:0]  htrans_m;
  logic [NM-1:0]    hwrite_m;
  logic [NM*3-1:0]  hsize_m;
  logic [NM*DW-1:0] hwdata_m;
  logic             hready_i;
  logic [AW-1:0]    haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [DW-1:0]    hwdata;
  logic             hsel;

  modport slave (
    input  hbusreq, hlock, haddr_m, htrans_m, hwrite_m, hsize_m, hwdata_m, hready_i,
    output hgrant, hmaster, hmaster_d, haddr, htrans, hwrite, hsize, hwdata, hsel
  );

  modport master (
    output hbusreq, hlock, haddr_m, htrans_m, hwrite_m, hsize_m, hwdata_m, hready_i,
    input  hgrant, hmaster, hmaster_d, haddr, htrans, hwrite, hsize, hwdata, hsel
  );
endinterface

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin pick over N requests.
//   req   : request vector
//   cur   : current owner; search starts at cur+1 and wraps, cur itself excluded
//   idx   : winning index (equals cur when found=0)
//   found : some master other than cur is requesting
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] others;

  assign others = req & ~(N'(1) << cur);
  assign found  = |others;
  assign idx    = IW'(rr_next(MAX_NM'(req), 3'(cur), N));

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter and address/write-data mux for one shared slave.
//   hclk, hreset_n : clock, synchronous active-low reset
//   bus (slave)    : requests/locks and per-master fields in; one-hot grant,
//                    address-phase owner (hmaster), data-phase owner
//                    (hmaster_d) and the muxed slave-side signals out
// A non-locked owner is forced to re-arbitrate after MAX_TENURE beats.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NM         = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int DEF_M      = 0,
  parameter int MAX_TENURE = 8
) (
  input  logic         hclk,
  input  logic         hreset_n,
  ahb_arbiter_if.slave bus
);

  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
  localparam logic [TW-1:0] TEN_MAX = TW'(MAX_TENURE - 1);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEF_M);

  // Grant index kept alongside the one-hot grant so no decode is needed.
  logic [NM-1:0] hgrant_q;
  logic [MW-1:0] g_q;
  logic [MW-1:0] m_q;
  logic [MW-1:0] d_q;
  logic [TW-1:0] tenure;

  logic [MW-1:0] pick_idx;
  logic          pick_found;
  logic [MW-1:0] g_nxt;
  logic          ten_clr;
  logic [1:0]    htrans_g;
  logic [1:0]    htrans_o;
  logic          switch_ok;
  logic          beat;

  ahb_rr_pick #(.N(NM)) u_pick (
    .req   (bus.hbusreq),
    .cur   (g_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign htrans_g = bus.htrans_m[int'(g_q)*2 +: 2];
  assign htrans_o = bus.htrans_m[int'(m_q)*2 +: 2];
  assign beat     = (htrans_o == HTRANS_NONSEQ) || (htrans_o == HTRANS_SEQ);

  // Never hand over mid-burst: the granted master must be idle or just starting.
  assign switch_ok = bus.hready_i && !bus.hlock[g_q] &&
                     ((htrans_g == HTRANS_IDLE) || (htrans_g == HTRANS_NONSEQ)) &&
                     (!bus.hbusreq[g_q] || (tenure == TEN_MAX));

  always_comb begin
    g_nxt   = g_q;
    ten_clr = 1'b0;
    if (switch_ok) begin
      if (pick_found)              g_nxt   = pick_idx;
      else if (bus.hbusreq[g_q])   ten_clr = 1'b1;   // sole requester re-earns a fresh tenure
      else                         g_nxt   = DEF_IDX;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      g_q      <= DEF_IDX;
      hgrant_q <= NM'(1) << DEF_IDX;
      m_q      <= DEF_IDX;
      d_q      <= DEF_IDX;
      tenure   <= '0;
    end else if (bus.hready_i) begin
      g_q      <= g_nxt;
      hgrant_q <= NM'(1) << g_nxt;
      m_q      <= g_q;
      d_q      <= m_q;
      if (g_nxt != g_q || ten_clr)
        tenure <= '0;
      else if (beat && tenure != TEN_MAX)
        tenure <= tenure + 1'b1;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = m_q;
  assign bus.hmaster_d = d_q;
  assign bus.haddr     = bus.haddr_m[int'(m_q)*AW +: AW];
  assign bus.htrans    = htrans_o;
  assign bus.hwrite    = bus.hwrite_m[m_q];
  assign bus.hsize     = bus.hsize_m[int'(m_q)*3 +: 3];
  assign bus.hwdata    = bus.hwdata_m[int'(d_q)*DW +: DW];
  assign bus.hsel      = (htrans_o != HTRANS_IDLE);

  a_grant_onehot : assert property (@(posedge hclk) disable iff (!hreset_n) $onehot(hgrant_q));

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hreset_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mem [0:3];
  logic        pend_w;
  logic [1:0]  pend_a;

  ahb_arbiter_if #(.NM(4), .AW(32), .DW(32)) bus ();

  ahb_arbiter #(.NM(4), .AW(32), .DW(32), .DEF_M(0), .MAX_TENURE(8)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  always #5 hclk = ~hclk;

  // Tiny slave: 4 words, write data lands one beat after the address phase.
  always @(posedge hclk) begin
    if (!hreset_n) begin
      pend_w <= 1'b0;
      pend_a <= 2'd0;
    end else if (bus.hready_i) begin
      if (pend_w) mem[pend_a] <= bus.hwdata;
      pend_w <= bus.hsel && bus.hwrite;
      pend_a <= bus.haddr[3:2];
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [31:0] wd);
    bus.htrans_m[i*2 +: 2]   = tr;
    bus.haddr_m[i*32 +: 32]  = a;
    bus.hwrite_m[i]          = w;
    bus.hsize_m[i*3 +: 3]    = HSIZE_WORD;
    bus.hwdata_m[i*32 +: 32] = wd;
  endtask

  task automatic do_reset();
    hreset_n     = 1'b0;
    bus.hbusreq  = '0;
    bus.hlock    = '0;
    bus.haddr_m  = '0;
    bus.htrans_m = '0;
    bus.hwrite_m = '0;
    bus.hsize_m  = '0;
    bus.hwdata_m = '0;
    bus.hready_i = 1'b1;
    tick();
    hreset_n = 1'b1;
  endtask

  initial begin
    // reset, idle bus
    do_reset();
    chk_eq("rst_hgrant",    64'(bus.hgrant),    64'h1);
    chk_eq("rst_hmaster",   64'(bus.hmaster),   64'h0);
    chk_eq("rst_hmaster_d", 64'(bus.hmaster_d), 64'h0);
    chk_eq("rst_hsel",      64'(bus.hsel),      64'h0);
    repeat (5) tick();
    chk_eq("idle_hgrant",   64'(bus.hgrant),    64'h1);
    chk_eq("idle_hmaster",  64'(bus.hmaster),   64'h0);
    chk_eq("idle_hsel",     64'(bus.hsel),      64'h0);

    // requests {1,2} from g=0: round-robin picks 1 first
    bus.hbusreq = 4'b0110;
    tick();
    chk_eq("rr_first", 64'(bus.hgrant), 64'h2);
    bus.hbusreq = 4'b0100;
    tick();
    chk_eq("rr_to_m2",     64'(bus.hgrant),  64'h4);
    chk_eq("rr_m1_owner",  64'(bus.hmaster), 64'h1);
    // master 2 single NONSEQ write of 0xA5 to 0x8
    set_m(2, HTRANS_NONSEQ, 32'h8, 1'b1, 32'h0);
    tick();
    chk_eq("wr_hmaster", 64'(bus.hmaster), 64'h2);
    chk_eq("wr_haddr",   64'(bus.haddr),   64'h8);
    chk_eq("wr_htrans",  64'(bus.htrans),  64'(HTRANS_NONSEQ));
    chk_eq("wr_hwrite",  64'(bus.hwrite),  64'h1);
    chk_eq("wr_hsel",    64'(bus.hsel),    64'h1);
    bus.hbusreq = 4'b0010;
    set_m(1, HTRANS_IDLE, 32'h0, 1'b0, 32'h11);
    tick();
    set_m(2, HTRANS_IDLE, 32'h8, 1'b0, 32'hA5);
    #1;
    chk_eq("wr_regrant_m1", 64'(bus.hgrant),    64'h2);
    chk_eq("wr_hmaster_d",  64'(bus.hmaster_d), 64'h2);
    chk_eq("wr_hwdata",     64'(bus.hwdata),    64'hA5);
    chk_eq("wr_dphase_sel", 64'(bus.hsel),      64'h0);
    tick();
    chk_eq("wd_hmaster",    64'(bus.hmaster),   64'h1);
    chk_eq("wd_hmaster_d",  64'(bus.hmaster_d), 64'h2);
    chk_eq("wd_follows_d",  64'(bus.hwdata),    64'hA5);
    chk_eq("mem_word2",     64'(mem[2]),        64'hA5);
    // BUSY passes through and still selects the slave
    set_m(1, HTRANS_BUSY, 32'h0, 1'b0, 32'h11);
    #1;
    chk_eq("busy_htrans", 64'(bus.htrans), 64'(HTRANS_BUSY));
    chk_eq("busy_hsel",   64'(bus.hsel),   64'h1);

    // locked master 3 holds the bus through 12+ beats
    do_reset();
    bus.hbusreq = 4'b1000;
    bus.hlock   = 4'b1000;
    tick();
    chk_eq("lock_grant", 64'(bus.hgrant), 64'h8);
    bus.hbusreq = 4'b1011;
    set_m(3, HTRANS_NONSEQ, 32'h40, 1'b0, 32'h0);
    for (int i = 0; i < 13; i++) begin
      tick();
      chk_eq($sformatf("lock_hold_%0d", i), 64'(bus.hgrant), 64'h8);
    end
    chk_eq("lock_owner", 64'(bus.hmaster), 64'h3);
    bus.hlock = 4'b0000;
    tick();
    chk_eq("unlock_to_m0", 64'(bus.hgrant), 64'h1);

    // tenure limit: masters 0 and 1 alternate every 8 edges
    do_reset();
    bus.hbusreq = 4'b0011;
    set_m(0, HTRANS_NONSEQ, 32'h0, 1'b0, 32'h0);
    set_m(1, HTRANS_NONSEQ, 32'h4, 1'b0, 32'h0);
    for (int n = 1; n <= 32; n++) begin
      tick();
      chk_eq($sformatf("ten_grant_%0d", n), 64'(bus.hgrant),
             ((n / 8) % 2 == 1) ? 64'h2 : 64'h1);
      if (n % 8 == 0) chk_eq($sformatf("ten_clear_%0d", n), 64'(dut.tenure), 64'h0);
      if (n == 7)     chk_eq("ten_sat_7", 64'(dut.tenure), 64'h7);
    end

    // hready stall freezes arbitration and the owner pipeline
    do_reset();
    bus.hbusreq = 4'b0010;
    tick();
    chk_eq("stall_pre_grant", 64'(bus.hgrant), 64'h2);
    bus.hbusreq  = 4'b0100;
    bus.hready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq($sformatf("stall_grant_%0d", i), 64'(bus.hgrant),    64'h2);
      chk_eq($sformatf("stall_hm_%0d", i),    64'(bus.hmaster),   64'h0);
      chk_eq($sformatf("stall_hmd_%0d", i),   64'(bus.hmaster_d), 64'h0);
    end
    bus.hready_i = 1'b1;
    tick();
    chk_eq("stall_rel_grant", 64'(bus.hgrant),    64'h4);
    chk_eq("stall_rel_hm",    64'(bus.hmaster),   64'h1);
    chk_eq("stall_rel_hmd",   64'(bus.hmaster_d), 64'h0);

    // reset while master 2 is mid-burst
    do_reset();
    bus.hbusreq = 4'b0100;
    tick();
    set_m(2, HTRANS_NONSEQ, 32'h20, 1'b1, 32'h0);
    tick();
    set_m(2, HTRANS_SEQ, 32'h24, 1'b1, 32'h0);
    tick();
    chk_eq("burst_htrans", 64'(bus.htrans),    64'(HTRANS_SEQ));
    chk_eq("burst_hmd",    64'(bus.hmaster_d), 64'h2);
    chk_eq("burst_tenure", 64'(dut.tenure),    64'h1);
    hreset_n = 1'b0;
    tick();
    chk_eq("mrst_hgrant", 64'(bus.hgrant),    64'h1);
    chk_eq("mrst_hm",     64'(bus.hmaster),   64'h0);
    chk_eq("mrst_hmd",    64'(bus.hmaster_d), 64'h0);
    chk_eq("mrst_tenure", 64'(dut.tenure),    64'h0);
    chk_eq("mrst_hsel",   64'(bus.hsel),      64'h0);
    hreset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
